// File: rtl/car_mode_ctrl.sv
// car_mode_ctrl: decodes Zigbee command bytes into manual, line-tracking and timed auto-park drive outputs.
// Every output is registered from the post-command state and the inputs sampled on the same edge.
module car_mode_ctrl #(
    parameter int SPD_W       = 8,
    parameter int DIST_W      = 8,
    parameter int N_LINE      = 4,
    parameter int CENTER_DEG  = 95,
    parameter int MIN_DEG     = 30,
    parameter int MAX_DEG     = 150,
    parameter int STEER_GAIN  = 15,
    parameter int SLOW_DELTA  = 3,
    parameter int OBST_DIST   = 20,
    parameter int PARK_NEAR   = 35,
    parameter int PARK_STOP   = 9,
    parameter int FWD_CYCLES  = 68750000,
    parameter int HOLD_CYCLES = 20000000
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd_data,
    input  logic [N_LINE-1:0] line_sense,
    input  logic [DIST_W-1:0] fwd_dist,
    input  logic [DIST_W-1:0] back_dist,
    output logic [SPD_W-1:0]  speed,
    output logic [8:0]        degree,
    output logic              direction,
    output logic              beep_en,
    output logic [1:0]        mode,
    output logic [2:0]        park_state,
    output logic              hold
);
    typedef enum logic [2:0] {IDLE, REV_IN, FWD_ADJ, REV_FIN, DONE} park_t;
    localparam int TMR_W = $clog2(FWD_CYCLES + 1);
    localparam int HLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [8:0] CTR = 9'(CENTER_DEG);

    park_t ps, n_ps;
    logic [TMR_W-1:0] tmr, n_tmr;
    logic [HLD_W-1:0] hold_cnt;
    logic [SPD_W-1:0] base, n_base, n_speed;
    logic [5:0] word, n_word;
    logic [1:0] n_mode;
    logic [8:0] n_degree;
    logic n_dir, n_beep, cmd, lost;
    int f, l, err, deg;

    function automatic logic [SPD_W-1:0] sat_add(input logic [SPD_W-1:0] a, input int b);
        logic [SPD_W:0] s;
        s = {1'b0, a} + (SPD_W + 1)'(b);
        return s[SPD_W] ? '1 : s[SPD_W-1:0];
    endfunction

    assign park_state = ps;

    // line error from the outermost black channels; steering saturates at the servo limits
    always_comb begin
        f = 0;
        l = 0;
        for (int i = N_LINE - 1; i >= 0; i--) f = line_sense[i] ? i : f;
        for (int i = 0; i < N_LINE; i++) l = line_sense[i] ? i : l;
        lost = line_sense == '0;
        err = f + l - (N_LINE - 1);
        deg = CENTER_DEG + err * STEER_GAIN;
        deg = deg < MIN_DEG ? MIN_DEG : deg > MAX_DEG ? MAX_DEG : deg;
    end

    // a command in the same cycle pre-empts any park step
    always_comb begin
        n_mode = mode;
        n_base = base;
        n_word = word;
        n_ps = ps;
        n_tmr = tmr;
        cmd = cmd_valid && !hold;
        if (cmd) begin
            if (cmd_data[7:6] == 2'b01)
                n_base = SPD_W'(cmd_data[5:0]);
            else begin
                n_mode = cmd_data[7:6];
                n_ps = cmd_data[7:6] == 2'b11 ? REV_IN : IDLE;
                n_tmr = '0;
                n_word = cmd_data[7:6] == 2'b00 ? cmd_data[5:0] : word;
            end
        end else if (mode == 2'b11) begin
            case (ps)
                REV_IN:  n_ps = back_dist < DIST_W'(PARK_NEAR) ? FWD_ADJ : REV_IN;
                FWD_ADJ: begin
                    n_ps = tmr == TMR_W'(FWD_CYCLES - 1) ? REV_FIN : FWD_ADJ;
                    n_tmr = tmr == TMR_W'(FWD_CYCLES - 1) ? '0 : tmr + 1'b1;
                end
                REV_FIN: n_ps = back_dist < DIST_W'(PARK_STOP) ? DONE : REV_FIN;
                default: ;
            endcase
        end
    end

    always_comb begin
        n_speed = '0;
        n_degree = CTR;
        n_dir = 1'b1;
        n_beep = 1'b0;
        case (n_mode)
            2'b00: begin
                n_degree = n_word[3:2] == 2'b01 ? 9'd30 : n_word[3:2] == 2'b10 ? 9'd90 : CTR;
                n_dir = n_word[1:0] != 2'b10;
                n_speed = ^n_word[1:0] && fwd_dist > DIST_W'(OBST_DIST) ? SPD_W'(35) : '0;
            end
            2'b10: if (!lost) begin
                n_degree = 9'(deg);
                n_speed = err == 0 ? n_base : n_base > SPD_W'(SLOW_DELTA) ? n_base - SPD_W'(SLOW_DELTA) : '0;
            end
            2'b11: case (n_ps)
                REV_IN:  {n_dir, n_degree, n_speed, n_beep} = {1'b0, 9'd120, sat_add(n_base, 8), 1'b1};
                FWD_ADJ: {n_dir, n_degree, n_speed, n_beep} = {1'b1, 9'd60, sat_add(n_base, 5), 1'b0};
                REV_FIN: {n_dir, n_degree, n_speed, n_beep} = {1'b0, CTR, sat_add(n_base, 5), 1'b1};
                default: ;
            endcase
            default: ;
        endcase
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            speed <= '0;
            degree <= CTR;
            direction <= 1'b1;
            beep_en <= 1'b0;
            mode <= 2'b00;
            ps <= IDLE;
            hold <= 1'b1;
            hold_cnt <= '0;
            base <= SPD_W'(15);
            word <= '0;
            tmr <= '0;
        end else if (hold) begin
            hold_cnt <= hold_cnt + 1'b1;
            hold <= hold_cnt != HLD_W'(HOLD_CYCLES - 1);
        end else begin
            mode <= n_mode;
            base <= n_base;
            word <= n_word;
            ps <= n_ps;
            tmr <= n_tmr;
            speed <= n_speed;
            degree <= n_degree;
            direction <= n_dir;
            beep_en <= n_beep;
        end
    end
endmodule

// File: tb/tb_car_mode_ctrl.sv
// tb_car_mode_ctrl: directed plus random stimulus; a cycle-level reference model queues expected outputs
// and an independent monitor pops and compares them one clock later.
module tb_car_mode_ctrl;
    localparam int SPD_W = 6;
    localparam int N_LINE = 8;
    localparam int FWD = 5;
    localparam int HOLD = 20;

    typedef struct packed {
        logic [SPD_W-1:0] speed;
        logic [8:0]       degree;
        logic             dir;
        logic             beep;
        logic [1:0]       mode;
        logic [2:0]       ps;
        logic             hold;
    } out_t;

    logic clk_50M = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0;
    logic [7:0] cmd_data = '0;
    logic [N_LINE-1:0] line_sense = '0;
    logic [7:0] fwd_dist = '0;
    logic [7:0] back_dist = '0;
    logic [SPD_W-1:0] speed;
    logic [8:0] degree;
    logic direction, beep_en, hold;
    logic [1:0] mode;
    logic [2:0] park_state;

    out_t exp_q[$];
    out_t m_exp, m_got;
    int tests = 0;
    int fails = 0;
    int pushed = 0;
    int m_hold, m_mode, m_base, m_phase, m_fwd;
    logic [5:0] m_word;
    int add_tab[5] = '{0, 8, 5, 5, 0};
    int deg_tab[5] = '{95, 120, 60, 95, 95};

    car_mode_ctrl #(.SPD_W(SPD_W), .N_LINE(N_LINE), .FWD_CYCLES(FWD), .HOLD_CYCLES(HOLD)) dut (
        .clk_50M(clk_50M), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .line_sense(line_sense), .fwd_dist(fwd_dist), .back_dist(back_dist),
        .speed(speed), .degree(degree), .direction(direction), .beep_en(beep_en),
        .mode(mode), .park_state(park_state), .hold(hold)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic model_step(input logic r, input logic cv, input logic [7:0] cd,
                              input logic [N_LINE-1:0] ls, input logic [7:0] fd,
                              input logic [7:0] bd, output out_t o);
        int f, l, e, d, s;
        logic frozen;
        frozen = r || m_hold > 0;
        if (r) begin
            m_hold = HOLD;
            m_mode = 0;
            m_base = 15;
            m_word = '0;
            m_phase = 0;
            m_fwd = 0;
        end else if (m_hold > 0)
            m_hold--;
        else if (cv) begin
            if (cd[7:6] == 2'b01)
                m_base = int'(cd[5:0]);
            else begin
                m_mode = int'(cd[7:6]);
                m_phase = m_mode == 3 ? 1 : 0;
                if (m_mode == 0) m_word = cd[5:0];
            end
        end else if (m_mode == 3) begin
            if (m_phase == 1 && bd < 8'd35) begin
                m_phase = 2;
                m_fwd = FWD;
            end else if (m_phase == 2) begin
                m_fwd--;
                if (m_fwd == 0) m_phase = 3;
            end else if (m_phase == 3 && bd < 8'd9)
                m_phase = 4;
        end
        o = '{speed: '0, degree: 9'd95, dir: 1'b1, beep: 1'b0, mode: 2'd0, ps: 3'd0, hold: m_hold > 0};
        if (!frozen) begin
            o.mode = 2'(m_mode);
            o.ps = 3'(m_phase);
            if (m_mode == 0) begin
                o.degree = m_word[3:2] == 2'd1 ? 9'd30 : m_word[3:2] == 2'd2 ? 9'd90 : 9'd95;
                o.dir = m_word[1:0] != 2'd2;
                o.speed = (m_word[1:0] == 2'd1 || m_word[1:0] == 2'd2) && fd > 8'd20 ? 6'd35 : 6'd0;
            end else if (m_mode == 2) begin
                f = -1;
                l = -1;
                for (int i = 0; i < N_LINE; i++)
                    if (ls[i]) begin
                        if (f < 0) f = i;
                        l = i;
                    end
                if (f >= 0) begin
                    e = f + l - (N_LINE - 1);
                    d = 95 + 15 * e;
                    d = d < 30 ? 30 : d > 150 ? 150 : d;
                    o.degree = 9'(d);
                    o.speed = 6'(e == 0 ? m_base : m_base > 3 ? m_base - 3 : 0);
                end
            end else if (m_mode == 3) begin
                o.degree = 9'(deg_tab[m_phase]);
                o.dir = !(m_phase == 1 || m_phase == 3);
                o.beep = !o.dir;
                s = m_base + add_tab[m_phase];
                o.speed = 6'(add_tab[m_phase] == 0 ? 0 : s > 63 ? 63 : s);
            end
        end
    endtask

    task automatic step(input logic r, input logic cv, input logic [7:0] cd,
                        input logic [N_LINE-1:0] ls, input logic [7:0] fd, input logic [7:0] bd);
        out_t o;
        @(negedge clk_50M);
        rst = r;
        cmd_valid = cv;
        cmd_data = cd;
        line_sense = ls;
        fwd_dist = fd;
        back_dist = bd;
        model_step(r, cv, cd, ls, fd, bd, o);
        exp_q.push_back(o);
        pushed++;
    endtask

    initial forever begin
        @(posedge clk_50M);
        #1;
        if (exp_q.size() > 0) begin
            m_exp = exp_q.pop_front();
            m_got = {speed, degree, direction, beep_en, mode, park_state, hold};
            tests++;
            if (m_got !== m_exp) begin
                fails++;
                $display("FAIL out#%0d got spd=%0d deg=%0d dir=%b beep=%b mode=%0d ps=%0d hold=%b required spd=%0d deg=%0d dir=%b beep=%b mode=%0d ps=%0d hold=%b",
                         tests, m_got.speed, m_got.degree, m_got.dir, m_got.beep, m_got.mode, m_got.ps, m_got.hold,
                         m_exp.speed, m_exp.degree, m_exp.dir, m_exp.beep, m_exp.mode, m_exp.ps, m_exp.hold);
            end
        end
    end

    initial begin
        repeat (3) step(1, 0, 8'h00, '0, 8'd50, 8'd60);
        repeat (HOLD) step(0, 1, 8'h05, '0, 8'd50, 8'd60);
        step(0, 1, 8'h45, 8'h18, 8'd50, 8'd60);
        step(0, 1, 8'h80, 8'h18, 8'd50, 8'd60);
        step(0, 0, 8'h00, 8'h06, 8'd50, 8'd60);
        step(0, 0, 8'h00, 8'h03, 8'd50, 8'd60);
        step(0, 0, 8'h00, 8'hC0, 8'd50, 8'd60);
        step(0, 0, 8'h00, 8'h00, 8'd50, 8'd60);
        step(0, 1, 8'h05, '0, 8'd50, 8'd60);
        step(0, 0, 8'h00, '0, 8'd20, 8'd60);
        step(0, 0, 8'h00, '0, 8'd21, 8'd60);
        step(0, 1, 8'h0A, '0, 8'd50, 8'd60);
        step(0, 1, 8'hC0, '0, 8'd50, 8'd60);
        repeat (3) step(0, 0, 8'h00, '0, 8'd50, 8'd60);
        repeat (8) step(0, 0, 8'h00, '0, 8'd50, 8'd30);
        repeat (3) step(0, 0, 8'h00, '0, 8'd50, 8'd8);
        step(0, 1, 8'hC0, '0, 8'd50, 8'd60);
        repeat (3) step(0, 0, 8'h00, '0, 8'd50, 8'd30);
        step(0, 1, 8'h00, '0, 8'd50, 8'd30);
        step(0, 1, 8'h05, '0, 8'd50, 8'd30);
        step(0, 1, 8'hC0, '0, 8'd50, 8'd60);
        step(0, 1, 8'h7F, '0, 8'd50, 8'd60);
        repeat (2) step(0, 0, 8'h00, '0, 8'd50, 8'd60);
        step(1, 0, 8'h00, '0, 8'd50, 8'd60);
        repeat (HOLD + 2) step(0, 1, 8'hC0, '0, 8'd50, 8'd60);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 999) == 0, $urandom_range(0, 15) == 0, 8'($urandom),
                 $urandom_range(0, 4) == 0 ? {N_LINE{1'b0}} : N_LINE'($urandom),
                 8'($urandom_range(0, 60)), 8'($urandom_range(0, 80)));
        repeat (2) @(negedge clk_50M);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected outputs never compared, required 0", exp_q.size());
        end
        tests++;
        if (tests - 2 != pushed) begin
            fails++;
            $display("FAIL count: %0d outputs compared, required %0d", tests - 2, pushed);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
